// File: rtl/uart_apb_regs_if.sv
// APB3 bus bundle between the APB bridge (master) and the UART register file (slave).
interface uart_apb_regs_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_apb_regs.sv
// UART APB3 register file: control, baud divisor, live status, sticky W1C flags with
// interrupt mask, and a DATA window that strobes the TX/RX FIFOs.
module uart_apb_regs #(
    parameter int unsigned          NUM_STAT  = 13,
    parameter int unsigned          DIV_W     = 16,
    parameter logic [DIV_W-1:0]     DIV_RESET = DIV_W'(434),
    parameter int unsigned          DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_apb_regs_if.slave       bus,
    input  logic [NUM_STAT-1:0]  stat_in,
    input  logic                 tx_full,
    input  logic                 rx_empty,
    input  logic [DATA_W-1:0]    rx_data,
    output logic [DATA_W-1:0]    tx_data,
    output logic                 tx_wr,
    output logic                 rx_rd,
    output logic [7:0]           ctrl,
    output logic [DIV_W-1:0]     baud_div,
    output logic                 irq
);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_BAUD   = 3'd1;
    localparam logic [2:0] A_STATUS = 3'd2;
    localparam logic [2:0] A_FLAGS  = 3'd3;
    localparam logic [2:0] A_INTEN  = 3'd4;
    localparam logic [2:0] A_DATA   = 3'd5;

    logic [31:0]         prdata_q;
    logic                pslverr_q;
    logic [NUM_STAT-1:0] status;
    logic [NUM_STAT-1:0] flags;
    logic [NUM_STAT-1:0] int_en;

    logic                setup_c;
    logic                wr_ok_c;
    logic [2:0]          word_c;
    logic [31:0]         rdata_c;
    logic                err_c;
    logic [NUM_STAT-1:0] clr_c;
    logic [NUM_STAT-1:0] set_c;
    logic                unused_bits;

    assign bus.PRDATA  = prdata_q;
    assign bus.PSLVERR = pslverr_q;
    assign bus.PREADY  = 1'b1;

    assign setup_c = bus.PSEL & ~bus.PENABLE;
    assign word_c  = bus.PADDR[4:2];
    // Error decision was latched at setup, so a write commits only if it was accepted then.
    assign wr_ok_c = bus.PSEL & bus.PENABLE & bus.PWRITE & ~pslverr_q;
    assign clr_c   = (wr_ok_c && word_c == A_FLAGS) ? bus.PWDATA[NUM_STAT-1:0] : '0;
    // STATUS already holds last cycle's stat_in, so it doubles as the edge-detect history.
    assign set_c   = stat_in & ~status;
    assign unused_bits = ^{bus.PADDR[1:0], bus.PWDATA};

    // Read data and error response for the address presented in the setup phase.
    always_comb begin
        rdata_c = '0;
        err_c   = 1'b0;
        case (word_c)
            A_CTRL:   rdata_c = 32'(ctrl);
            A_BAUD:   rdata_c = 32'(baud_div);
            A_STATUS: begin
                rdata_c = 32'(status);
                err_c   = bus.PWRITE;
            end
            A_FLAGS:  rdata_c = 32'(flags);
            A_INTEN:  rdata_c = 32'(int_en);
            A_DATA: begin
                if (bus.PWRITE) begin
                    err_c = tx_full;
                end else if (rx_empty) begin
                    err_c = 1'b1;
                end else begin
                    rdata_c = 32'(rx_data);
                end
            end
            default:  err_c = 1'b1;
        endcase
    end

    // Bus response and RX pop strobe, both launched from the setup edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            rx_rd     <= 1'b0;
        end else begin
            pslverr_q <= setup_c & err_c;
            rx_rd     <= setup_c & ~bus.PWRITE & (word_c == A_DATA) & ~rx_empty;
            if (setup_c && !bus.PWRITE) begin
                prdata_q <= rdata_c;
            end
        end
    end

    // Writable registers and TX push, committed on the access edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            baud_div <= DIV_RESET;
            int_en   <= '0;
            tx_data  <= '0;
            tx_wr    <= 1'b0;
        end else begin
            tx_wr <= wr_ok_c & (word_c == A_DATA);
            if (wr_ok_c) begin
                case (word_c)
                    A_CTRL:  ctrl     <= bus.PWDATA[7:0];
                    A_BAUD:  baud_div <= bus.PWDATA[DIV_W-1:0];
                    A_INTEN: int_en   <= bus.PWDATA[NUM_STAT-1:0];
                    A_DATA:  tx_data  <= bus.PWDATA[DATA_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Status snapshot, sticky flags (set beats clear) and registered interrupt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status <= '0;
            flags  <= '0;
            irq    <= 1'b0;
        end else begin
            status <= stat_in;
            flags  <= (flags & ~clr_c) | set_c;
            irq    <= |(flags & int_en);
        end
    end

endmodule
